// File: rtl/itof_arb.sv
// itof_arb: round-robin arbiter sharing one int32 -> float32 converter between
// NREQ requesters. The pipeline has two registered stages: S1 holds the operand,
// and S2 holds the response. Both sides use valid/ready handshakes.
// Optional build macro ITOF_ARB_STATS_EN adds the stat_conv and stat_stall counters.
module itof_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [TAG_W-1:0]     resp_tag
`ifdef ITOF_ARB_STATS_EN
  ,
  output logic [31:0]          stat_conv,
  output logic [31:0]          stat_stall
`endif
);

  // Signed int32 to IEEE-754 single. The result is round-to-nearest, and a tie
  // rounds up in magnitude.
  function automatic logic [31:0] itof(input logic [31:0] a);
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  p;
    logic [31:0] norm;
    logic [24:0] m;
    logic [7:0]  e;
    sign = a[31];
    mag  = sign ? (~a + 32'd1) : a;
    p    = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) p = 5'(i);
    end
    if (mag == 32'd0) begin
      itof = 32'd0;
    end else begin
      // Shift the leading one to bit 31. Bit 7 then becomes the rounding guard bit.
      norm = mag << (5'd31 - p);
      m    = {1'b0, norm[31:8]} + {24'd0, norm[7]};
      e    = 8'd127 + {3'b000, p};
      // Rounding can carry out to 2^24. Bump the exponent and leave the mantissa zero.
      e    = e + {7'd0, m[24]};
      itof = {sign, e, m[22:0]};
    end
  endfunction

  logic              r_s1_valid;
  logic [31:0]       r_s1_data;
  logic [TAG_W-1:0]  r_s1_tag;
  logic [TAG_W-1:0]  r_rr_ptr;
  logic              r_resp_valid;
  logic [31:0]       r_resp_data;
  logic [TAG_W-1:0]  r_resp_tag;

  logic              w_found;
  logic [TAG_W-1:0]  w_gnt_idx;
  logic [31:0]       w_gnt_data;
  logic              w_s2_load;
  logic              w_s1_free;
  logic              w_accept;

  // Round-robin search that starts just after the last granted requester.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(r_rr_ptr) + 1 + k) % int'(NREQ);
      if (!w_found && req_valid[idx]) begin
        w_found    = 1'b1;
        w_gnt_idx  = TAG_W'(idx);
        w_gnt_data = req_data[32*idx +: 32];
      end
    end
  end

  // Pipeline advance conditions and the one-hot accept.
  always_comb begin
    w_s2_load = r_s1_valid & (~r_resp_valid | resp_ready);
    w_s1_free = ~r_s1_valid | w_s2_load;
    w_accept  = w_s1_free & w_found & ~flush;
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_idx] = 1'b1;
  end

  // Stage 1 operand register and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_tag   <= '0;
      r_rr_ptr   <= TAG_W'(NREQ - 1);
    end else begin
      if (w_accept) r_rr_ptr <= w_gnt_idx;
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= w_gnt_data;
        r_s1_tag   <= w_gnt_idx;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 response register. Data and tag keep their values after the consumer takes them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else if (flush) begin
      r_resp_valid <= 1'b0;
    end else if (w_s2_load) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= itof(r_s1_data);
      r_resp_tag   <= r_s1_tag;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_tag   = r_resp_tag;

`ifdef ITOF_ARB_STATS_EN
  logic [31:0] r_stat_conv;
  logic [31:0] r_stat_stall;

  // Handshake and stall counters. Flush does not clear them, and they wrap at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_conv  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_resp_valid & resp_ready)  r_stat_conv  <= r_stat_conv + 32'd1;
      if (r_resp_valid & ~resp_ready) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_conv  = r_stat_conv;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_itof_arb.sv
// Self-checking bench for itof_arb with NREQ=4 and TAG_W=2.
// Inputs are driven on the falling edge. Outputs are sampled 1ns later, well before the rising edge.
module tb_itof_arb;

  logic         clk;
  logic         rstn;
  logic         flush;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_tag;
`ifdef ITOF_ARB_STATS_EN
  logic [31:0]  stat_conv;
  logic [31:0]  stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  itof_arb #(.NREQ(4), .TAG_W(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
`ifdef ITOF_ARB_STATS_EN
    ,
    .stat_conv  (stat_conv),
    .stat_stall (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   v;
    logic         fl;
    logic         rr;
    logic [127:0] data;
    logic [3:0]   er;
    logic         ev;
    logic [31:0]  ed;
    logic [1:0]   et;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive the inputs, then check the comb ready and the registered response.
  task automatic step(input string nm, input logic [3:0] v, input logic fl, input logic rr,
                      input logic [3:0] er, input logic ev, input logic [31:0] ed,
                      input logic [1:0] et);
    @(negedge clk);
    req_valid  = v;
    flush      = fl;
    resp_ready = rr;
    #1;
    chk({nm, ".req_ready"}, {28'd0, req_ready}, {28'd0, er});
    chk({nm, ".resp_valid"}, {31'd0, resp_valid}, {31'd0, ev});
    chk({nm, ".resp_data"}, resp_data, ed);
    chk({nm, ".resp_tag"}, {30'd0, resp_tag}, {30'd0, et});
  endtask

  localparam logic [127:0] DRR = {32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'd100};
  localparam logic [127:0] D0  = {32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'd3};
  // Requester 2 holds 2^24+1, an exact tie, which rounds up to 0x4B800001.
  localparam logic [127:0] DBP = {32'h7FFF_FFFF, 32'd16777217, 32'hFFFF_FFF9, 32'd5};

  initial begin
    // Single-requester latency, then a 4-way round robin. After the first
    // grant to 0 the pointer is 0, so the order continues 1,2,3,0.
    tbl[0] = '{4'b0001, 1'b0, 1'b1, D0,  4'b0001, 1'b0, 32'h0000_0000, 2'd0};
    tbl[1] = '{4'b0000, 1'b0, 1'b1, D0,  4'b0000, 1'b0, 32'h0000_0000, 2'd0};
    tbl[2] = '{4'b0000, 1'b0, 1'b1, D0,  4'b0000, 1'b1, 32'h4040_0000, 2'd0};
    tbl[3] = '{4'b1111, 1'b0, 1'b1, DRR, 4'b0010, 1'b0, 32'h4040_0000, 2'd0};
    tbl[4] = '{4'b1111, 1'b0, 1'b1, DRR, 4'b0100, 1'b0, 32'h4040_0000, 2'd0};
    tbl[5] = '{4'b1111, 1'b0, 1'b1, DRR, 4'b1000, 1'b1, 32'hBF80_0000, 2'd1};
    tbl[6] = '{4'b1111, 1'b0, 1'b1, DRR, 4'b0001, 1'b1, 32'h0000_0000, 2'd2};
    tbl[7] = '{4'b0000, 1'b0, 1'b1, DRR, 4'b0000, 1'b1, 32'hCF00_0000, 2'd3};
    tbl[8] = '{4'b0000, 1'b0, 1'b1, DRR, 4'b0000, 1'b1, 32'h42C8_0000, 2'd0};
    tbl[9] = '{4'b0000, 1'b0, 1'b1, DRR, 4'b0000, 1'b0, 32'h42C8_0000, 2'd0};

    rstn       = 1'b0;
    flush      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    #1;
    chk("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset.resp_data", resp_data, 32'd0);
    chk("reset.resp_tag", {30'd0, resp_tag}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid  = tbl[i].v;
      flush      = tbl[i].fl;
      resp_ready = tbl[i].rr;
      req_data   = tbl[i].data;
      #1;
      chk($sformatf("tbl%0d.req_ready", i), {28'd0, req_ready}, {28'd0, tbl[i].er});
      chk($sformatf("tbl%0d.resp_valid", i), {31'd0, resp_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d.resp_data", i), resp_data, tbl[i].ed);
      chk($sformatf("tbl%0d.resp_tag", i), {30'd0, resp_tag}, {30'd0, tbl[i].et});
    end

    // Backpressure with requesters 0,1,2 valid and rr_ptr=0. Exactly two
    // accepts (1 then 2) happen, then ready drops and the output holds.
    req_data = DBP;
    step("bp0", 4'b0111, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h42C8_0000, 2'd0);
    step("bp1", 4'b0111, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h42C8_0000, 2'd0);
    step("bp2", 4'b0111, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hC0E0_0000, 2'd1);
    step("bp3", 4'b0111, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hC0E0_0000, 2'd1);
    step("bp4", 4'b0111, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hC0E0_0000, 2'd1);
    // On release the pointer is still 2, so requester 0 is next.
    step("bp5", 4'b0111, 1'b0, 1'b1, 4'b0001, 1'b1, 32'hC0E0_0000, 2'd1);
    step("bp6", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h4B80_0001, 2'd2);
    step("bp7", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h40A0_0000, 2'd0);
    step("bp8", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h40A0_0000, 2'd0);

    // Grant 3, then 1 and 3 contend: 1 wins, then stall, then 3 wins.
    step("rr0", 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0, 32'h40A0_0000, 2'd0);
    step("rr1", 4'b1010, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h40A0_0000, 2'd0);
    step("rr2", 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h4F00_0000, 2'd3);
    step("rr3", 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h4F00_0000, 2'd3);
    step("rr4", 4'b1010, 1'b0, 1'b1, 4'b1000, 1'b1, 32'h4F00_0000, 2'd3);
    step("rr5", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hC0E0_0000, 2'd1);
    step("rr6", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h4F00_0000, 2'd3);
    step("rr7", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h4F00_0000, 2'd3);

    // Flush with S1 and S2 full: no accept, and then the order continues from rr_ptr=1.
    step("fl0", 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h4F00_0000, 2'd3);
    step("fl1", 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h4F00_0000, 2'd3);
    step("fl2", 4'b0110, 1'b1, 1'b1, 4'b0000, 1'b1, 32'h40A0_0000, 2'd0);
    step("fl3", 4'b0110, 1'b0, 1'b1, 4'b0100, 1'b0, 32'h40A0_0000, 2'd0);
    step("fl4", 4'b0110, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h40A0_0000, 2'd0);
    step("fl5", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h4B80_0001, 2'd2);
    step("fl6", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hC0E0_0000, 2'd1);
    step("fl7", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'hC0E0_0000, 2'd1);

    // Mid-stream asynchronous reset. The pointer is 1, so grants go to 2 and then 3.
    step("rs0", 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b0, 32'hC0E0_0000, 2'd1);
    step("rs1", 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b0, 32'hC0E0_0000, 2'd1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("rs.pre_valid", {31'd0, resp_valid}, 32'd1);
    chk("rs.pre_data", resp_data, 32'h4B80_0001);
    #2;
    rstn = 1'b0;
    #1;
    chk("rs.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rs.resp_data", resp_data, 32'd0);
    chk("rs.resp_tag", {30'd0, resp_tag}, 32'd0);
`ifdef ITOF_ARB_STATS_EN
    chk("rs.stat_conv", stat_conv, 32'd0);
    chk("rs.stat_stall", stat_stall, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    req_data = D0;
    step("pr0", 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0000_0000, 2'd0);
    step("pr1", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0000_0000, 2'd0);
    step("pr2", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h4040_0000, 2'd0);
    step("pr3", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h4040_0000, 2'd0);
`ifdef ITOF_ARB_STATS_EN
    chk("pr.stat_conv", stat_conv, 32'd1);
    chk("pr.stat_stall", stat_stall, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
